// File: rtl/wishbone_timer_pkg.sv
// wb_timer_pkg: register map constants and byte-lane merge helper for the timer
package wb_timer_pkg;
  localparam logic [1:0] CTRL_OFS  = 2'd0;
  localparam logic [1:0] COUNT_OFS = 2'd1;
  localparam logic [1:0] CMP_OFS   = 2'd2;
  localparam logic [1:0] STAT_OFS  = 2'd3;
  localparam int EN_BIT  = 0;
  localparam int AR_BIT  = 1;
  localparam int IE_BIT  = 2;
  localparam int DIV_LSB = 16;

  function automatic logic [31:0] apply_sel(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/wishbone_timer_if.sv
// wishbone_timer_if: peripheral bus signals between the core and the timer responder
interface wishbone_timer_if #(parameter int ADR_W = 16);
  logic             cyc_i;
  logic             stb_i;
  logic             we_i;
  logic [3:0]       sel_i;
  logic [ADR_W-1:0] adr_i;
  logic [31:0]      dat_i;
  logic             ack_o;
  logic [31:0]      dat_o;
  modport slave  (input cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, output ack_o, dat_o);
  modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, input ack_o, dat_o);
endinterface

// File: rtl/wishbone_timer_prescaler.sv
// timer_prescaler: divides the clock by div+1 while enabled, emitting one-cycle ticks
module timer_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] pcnt;

  assign tick = en && pcnt == div;

  // count up while enabled, restart on a tick; a lowered div lets pcnt wrap naturally
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) pcnt <= '0;
    else pcnt <= (tick || !en) ? '0 : pcnt + 1'b1;
endmodule

// File: rtl/wishbone_timer.sv
// wishbone_timer: bus-mapped prescaled 32-bit counter with compare match and level irq
module wishbone_timer
  import wb_timer_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int ADR_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  wishbone_timer_if.slave  bus,
  output logic             irq_o
);
  localparam logic [63:0] DIV_MASK  = (64'd1 << (DIV_LSB + DIV_W)) - 64'd1;
  localparam logic [31:0] CTRL_MASK = DIV_MASK[31:0] & 32'hFFFF_0007;

  logic [31:0] ctrl, count, cmp;
  logic        match, tick, tick_eff, hit, wr, unused_adr;
  logic [1:0]  ofs;

  assign hit        = bus.adr_i[ADR_W-1:4] == '0;
  assign ofs        = bus.adr_i[3:2];
  assign unused_adr = ^bus.adr_i[1:0];
  assign wr         = bus.cyc_i && bus.stb_i && bus.we_i && !bus.ack_o && hit;
  // a write that clears EN on a tick cycle swallows that tick
  assign tick_eff   = tick && !(wr && ofs == CTRL_OFS && bus.sel_i[0] && !bus.dat_i[EN_BIT]);
  assign bus.dat_o  = !hit ? '0 :
                      ofs == CTRL_OFS  ? ctrl  :
                      ofs == COUNT_OFS ? count :
                      ofs == CMP_OFS   ? cmp   : {31'b0, match};

  timer_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en     (ctrl[EN_BIT]),
    .div    (ctrl[DIV_LSB +: DIV_W]),
    .tick   (tick)
  );

  // single-cycle ack pulse; a held strobe is acked every other cycle
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) bus.ack_o <= 1'b0;
    else bus.ack_o <= bus.cyc_i && bus.stb_i && !bus.ack_o;

  // register file: bus writes beat counter updates, a new match beats a W1C clear
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      ctrl  <= '0;
      count <= '0;
      cmp   <= '0;
      match <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      irq_o <= match && ctrl[IE_BIT];
      if (wr && ofs == CTRL_OFS) ctrl <= apply_sel(ctrl, bus.dat_i, bus.sel_i) & CTRL_MASK;
      if (wr && ofs == CMP_OFS) cmp <= apply_sel(cmp, bus.dat_i, bus.sel_i);
      if (wr && ofs == COUNT_OFS) count <= apply_sel(count, bus.dat_i, bus.sel_i);
      else if (tick_eff) count <= (count == cmp && ctrl[AR_BIT]) ? '0 : count + 32'd1;
      if (tick_eff && count == cmp) match <= 1'b1;
      else if (wr && ofs == STAT_OFS && bus.sel_i[0] && bus.dat_i[0]) match <= 1'b0;
    end
endmodule

// File: tb/tb_wishbone_timer.sv
// tb_wishbone_timer: directed self-checking bench for the wishbone timer
module tb_wishbone_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};

  wishbone_timer_if #(.ADR_W(16)) bus ();

  wishbone_timer #(.DIV_W(16), .ADR_W(16)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus.slave),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    bus.adr_i = a;
    #1;
    chk(tag, bus.dat_o, exp);
  endtask

  task automatic wb_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = a; bus.dat_i = d; bus.sel_i = s;
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    bus.sel_i = 4'h0; bus.adr_i = 16'h0; bus.dat_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, bus.ack_o}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk_rd("rst_ctrl", 16'h0, 32'h0);
    chk_rd("rst_count", 16'h4, 32'h0);
    chk_rd("rst_cmp", 16'h8, 32'h0);
    chk_rd("rst_stat", 16'hC, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // held read strobe: ack every other cycle
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 16'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_ack", {31'b0, bus.ack_o}, {31'b0, i[0]});
      chk("hold_dat", bus.dat_o, 32'h0);
    end
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    @(posedge clk); #1;
    // free-running count with compare=5, DIV=0, IE
    wb_write(16'h8, 32'h5, 4'hF);
    wb_write(16'h0, 32'h5, 4'hF);
    bus.adr_i = 16'h4;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("run_count", bus.dat_o, i);
    end
    @(negedge clk);
    chk("run_count6", bus.dat_o, 32'd6);
    chk("run_irq_lag", {31'b0, irq}, 32'd0);
    chk_rd("run_match", 16'hC, 32'd1);
    @(negedge clk);
    chk("run_irq", {31'b0, irq}, 32'd1);
    // DIV=3 with auto-reload, compare=2, IE off
    wb_write(16'h0, 32'h0, 4'hF);
    wb_write(16'hC, 32'h1, 4'hF);
    wb_write(16'h4, 32'h0, 4'hF);
    wb_write(16'h8, 32'h2, 4'hF);
    chk("ar_irq_clr", {31'b0, irq}, 32'd0);
    wb_write(16'h0, 32'h0003_0003, 4'hF);
    bus.adr_i = 16'h4;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("ar_count", bus.dat_o, exp_cnt[k]);
    end
    @(negedge clk);
    chk_rd("ar_match", 16'hC, 32'd1);
    chk("ar_irq", {31'b0, irq}, 32'd0);
    // byte-lane writes with the timer stopped
    wb_write(16'h0, 32'h0, 4'hF);
    wb_write(16'h4, 32'hAABB_CCDD, 4'hF);
    wb_write(16'h4, 32'h1122_3344, 4'b0101);
    chk_rd("sel_merge", 16'h4, 32'hAA22_CC44);
    wb_write(16'h4, 32'hFFFF_FFFF, 4'b0000);
    chk_rd("sel_none", 16'h4, 32'hAA22_CC44);
    wb_write(16'h0, 32'hFFFF_FFF8, 4'hF);
    chk_rd("ctrl_rsvd", 16'h0, 32'hFFFF_0000);
    wb_write(16'h0, 32'h0, 4'hF);
    // W1C on the same edge as a new match: set wins
    wb_write(16'h8, 32'd10, 4'hF);
    wb_write(16'h4, 32'd10, 4'hF);
    chk_rd("pre_match", 16'hC, 32'd1);
    wb_write(16'h0, 32'h0001_0005, 4'hF);
    wb_write(16'hC, 32'h1, 4'hF);
    chk_rd("setwins_match", 16'hC, 32'd1);
    chk_rd("setwins_count", 16'h4, 32'd11);
    wb_write(16'h0, 32'h4, 4'hF);
    chk("irq_on", {31'b0, irq}, 32'd1);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 16'hC; bus.dat_i = 32'h1; bus.sel_i = 4'hF;
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    @(negedge clk);
    chk("w1c_match", bus.dat_o, 32'd0);
    chk("w1c_irq_lag", {31'b0, irq}, 32'd1);
    @(negedge clk);
    chk("w1c_irq", {31'b0, irq}, 32'd0);
    // unmapped write is acked and ignored
    @(posedge clk); #1;
    wb_write(16'h4, 32'h1234, 4'hF);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 16'h10; bus.dat_i = 32'hFFFF_FFFF; bus.sel_i = 4'hF;
    @(negedge clk);
    chk("unmap_ack0", {31'b0, bus.ack_o}, 32'd0);
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    @(negedge clk);
    chk("unmap_ack1", {31'b0, bus.ack_o}, 32'd1);
    chk_rd("unmap_rd", 16'h10, 32'h0);
    chk_rd("unmap_ctrl", 16'h0, 32'h4);
    chk_rd("unmap_count", 16'h4, 32'h1234);
    chk_rd("unmap_cmp", 16'h8, 32'd10);
    chk_rd("unmap_stat", 16'hC, 32'h0);
    // asynchronous reset in the middle of a strobed cycle
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 16'h4; bus.dat_i = 32'hDEAD; bus.sel_i = 4'hF;
    @(posedge clk); #2;
    chk("mid_ack", {31'b0, bus.ack_o}, 32'd1);
    bus.adr_i = 16'h8; bus.dat_i = 32'h55;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ack", {31'b0, bus.ack_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    chk("rst2_irq", {31'b0, irq}, 32'd0);
    chk_rd("rst2_ctrl", 16'h0, 32'h0);
    chk_rd("rst2_count", 16'h4, 32'h0);
    chk_rd("rst2_cmp", 16'h8, 32'h0);
    chk_rd("rst2_stat", 16'hC, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
